// File: rtl/pmem_pkg.sv
// -----------------------------------------------------------------------------
// pmem_pkg
// Shared definitions for the cache-side physical-memory line responder:
// responder state encoding, line/beat geometry and an address-alignment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package pmem_pkg;

    localparam int BEAT_WIDTH  = 64;
    localparam int BURST_BEATS = 4;
    localparam int LINE_WIDTH  = BEAT_WIDTH * BURST_BEATS;
    localparam int OFFSET_BITS = 5;
    localparam int ADDR_WIDTH  = 32;
    localparam int CNT_WIDTH   = $clog2(BURST_BEATS);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } resp_state_t;

    // Clears the byte-within-line offset so bursts always start on a line boundary.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/pmem_line_buffer.sv
// -----------------------------------------------------------------------------
// pmem_line_buffer
// One cache line held as BURST_BEATS beat-wide slices. Supports a full-line
// load (write requests) and a single-beat write (read bursts), plus a
// beat-indexed read port used to serialize write bursts.
//
// Ports:
//   clk          clock
//   srst_i       synchronous active-high reset, clears the whole line
//   load_en_i    load load_line_i into the entire line
//   load_line_i  full line to load
//   beat_we_i    write beat_data_i into slice beat_idx_i
//   beat_idx_i   slice index for beat write and beat read
//   beat_data_i  beat to write
//   line_o       whole line
//   beat_o       slice selected by beat_idx_i
// -----------------------------------------------------------------------------
module pmem_line_buffer
    import pmem_pkg::*;
(
    input  logic                  clk,
    input  logic                  srst_i,
    input  logic                  load_en_i,
    input  logic [LINE_WIDTH-1:0] load_line_i,
    input  logic                  beat_we_i,
    input  logic [CNT_WIDTH-1:0]  beat_idx_i,
    input  logic [BEAT_WIDTH-1:0] beat_data_i,
    output logic [LINE_WIDTH-1:0] line_o,
    output logic [BEAT_WIDTH-1:0] beat_o
);

    logic [BEAT_WIDTH-1:0] beats [BURST_BEATS];

    generate
        for (genvar gi = 0; gi < BURST_BEATS; gi++) begin : g_slice
            logic [BEAT_WIDTH-1:0] slice_q;

            // A full-line load wins over a beat write; the two never coincide
            // in the responder, but the priority keeps the slice well defined.
            always_ff @(posedge clk) begin
                if (srst_i) begin
                    slice_q <= '0;
                end else if (load_en_i) begin
                    slice_q <= load_line_i[gi*BEAT_WIDTH +: BEAT_WIDTH];
                end else if (beat_we_i && (beat_idx_i == CNT_WIDTH'(gi))) begin
                    slice_q <= beat_data_i;
                end
            end

            assign beats[gi] = slice_q;
            assign line_o[gi*BEAT_WIDTH +: BEAT_WIDTH] = slice_q;
        end
    endgenerate

    assign beat_o = beats[beat_idx_i];

endmodule

// File: rtl/pmem_line_responder.sv
// -----------------------------------------------------------------------------
// pmem_line_responder
// Responder end of the cache-to-physical-memory line interface. Takes 256-bit
// line read/write requests and completes them as 4-beat, 64-bit bursts.
// Read beats are reassembled into the line buffer; write lines are serialized
// from it. Completion is a single-cycle pmem_resp pulse.
//
// Build option:
//   PMEM_POSTED_WRITE_EN  when defined, writes respond the cycle after they are
//                         latched and the burst drains in the background; any
//                         new request waits until that burst has finished.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   pmem_read      line read request, held until pmem_resp
//   pmem_write     line write request, held until pmem_resp (wins over read)
//   pmem_address   line address, low 5 bits ignored
//   pmem_wdata     write line
//   pmem_rdata     read line, meaningful while pmem_resp
//   pmem_resp      one-cycle completion pulse
//   burst_read     burst read request
//   burst_write    burst write request
//   burst_address  latched line-aligned address
//   burst_wdata    current write beat
//   burst_rdata    current read beat
//   burst_resp     beat handshake
// -----------------------------------------------------------------------------
module pmem_line_responder
    import pmem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [ADDR_WIDTH-1:0] burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    resp_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  buf_load;
    logic                  buf_beat_we;
    logic                  last_beat;
`ifdef PMEM_POSTED_WRITE_EN
    logic                  posted_resp_q, posted_resp_d;
`endif

    assign last_beat = (beat_cnt_q == CNT_WIDTH'(BURST_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            addr_q        <= '0;
`ifdef PMEM_POSTED_WRITE_EN
            posted_resp_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            addr_q        <= addr_d;
`ifdef PMEM_POSTED_WRITE_EN
            posted_resp_q <= posted_resp_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        addr_d        = addr_q;
        buf_load      = 1'b0;
        buf_beat_we   = 1'b0;
`ifdef PMEM_POSTED_WRITE_EN
        posted_resp_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    addr_d        = line_align(pmem_address);
                    beat_cnt_d    = '0;
                    buf_load      = 1'b1;
                    state_d       = WRITE;
`ifdef PMEM_POSTED_WRITE_EN
                    posted_resp_d = 1'b1;
`endif
                end else if (pmem_read) begin
                    addr_d     = line_align(pmem_address);
                    beat_cnt_d = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (burst_resp) begin
                    buf_beat_we = 1'b1;
                    // Counter holds on the final beat so it never wraps mid-burst.
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    if (last_beat) begin
`ifdef PMEM_POSTED_WRITE_EN
                        // Already acknowledged when latched; no second pulse.
                        state_d = IDLE;
`else
                        state_d = DONE;
`endif
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    pmem_line_buffer u_line_buffer (
        .clk         (clk),
        .srst_i      (rst),
        .load_en_i   (buf_load),
        .load_line_i (pmem_wdata),
        .beat_we_i   (buf_beat_we),
        .beat_idx_i  (beat_cnt_q),
        .beat_data_i (burst_rdata),
        .line_o      (pmem_rdata),
        .beat_o      (burst_wdata)
    );

    // All outputs come from registered state only.
    assign burst_read    = (state_q == READ);
    assign burst_write   = (state_q == WRITE);
    assign burst_address = addr_q;
`ifdef PMEM_POSTED_WRITE_EN
    assign pmem_resp     = (state_q == DONE) || posted_resp_q;
`else
    assign pmem_resp     = (state_q == DONE);
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_pmem_line_responder
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a transaction-level
// reference model (busy flag, beats-done counter, expected line).
// -----------------------------------------------------------------------------
module tb_pmem_line_responder;

`ifdef PMEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [31:0]  pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata = '0;
    logic         burst_resp = 1'b0;

    always #5 clk = ~clk;

    pmem_line_responder dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit           m_valid = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_is_wr = 1'b0;
    bit           m_resp = 1'b0;
    bit           m_resp_rd = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [255:0] m_line = '0;
    int           m_beats = 0;

    // Inputs change just after posedge, so at negedge they are exactly what the
    // DUT samples at the next posedge: compare first, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("burst_read", burst_read, m_busy && !m_is_wr);
                check("burst_write", burst_write, m_busy && m_is_wr);
                check("pmem_resp", pmem_resp, m_resp);
                check("burst_address", burst_address, m_addr);
                if (m_busy && m_is_wr)
                    check("burst_wdata", burst_wdata, m_line[64*m_beats +: 64]);
                if (m_resp && m_resp_rd)
                    check("pmem_rdata", pmem_rdata, m_line);
            end
            if (rst) begin
                m_valid = 1'b1; m_busy = 1'b0; m_resp = 1'b0; m_resp_rd = 1'b0;
                m_addr = '0; m_line = '0; m_beats = 0;
            end else if (m_valid) begin
                bit nr, nrr;
                nr = 1'b0; nrr = 1'b0;
                if (m_busy) begin
                    if (burst_resp) begin
                        if (!m_is_wr) m_line[64*m_beats +: 64] = burst_rdata;
                        m_beats++;
                        if (m_beats == 4) begin
                            m_busy = 1'b0;
                            nr  = !(POSTED && m_is_wr);
                            nrr = !m_is_wr;
                        end
                    end
                end else if (m_resp) begin
                    // completion cycle: requests ignored
                end else if (pmem_write) begin
                    m_busy = 1'b1; m_is_wr = 1'b1; m_beats = 0;
                    m_addr = {pmem_address[31:5], 5'b0};
                    m_line = pmem_wdata;
                    nr = POSTED;
                end else if (pmem_read) begin
                    m_busy = 1'b1; m_is_wr = 1'b0; m_beats = 0;
                    m_addr = {pmem_address[31:5], 5'b0};
                end
                m_resp = nr; m_resp_rd = nrr;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_mem();
        burst_resp  = ($urandom % 100) < 60;
        burst_rdata = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] pat(input int k);
        return 64'h1111_1111_1111_1111 * 64'(k + 1);
    endfunction

    task automatic wait_resp();
        int n = 0;
        while (!pmem_resp && n < 100) begin
            rand_mem();
            tick();
            n++;
        end
        check("resp_within_budget", pmem_resp, 1'b1);
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        rand_mem();
        tick();
    endtask

    task automatic drain();
        int n = 0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        while ((burst_read || burst_write || pmem_resp) && n < 50) begin
            burst_resp = 1'b1;
            burst_rdata = {$urandom, $urandom};
            tick();
            n++;
        end
        check("drain_within_budget", burst_read || burst_write, 1'b0);
        burst_resp = 1'b0;
        tick();
    endtask

    logic [63:0] exp_w [4];

    initial begin
        int lat, k, wb;
        bit done;
        logic [255:0] wline;

        exp_w[0] = 64'h0000_0000_0000_BEEF;
        exp_w[1] = 64'h1111_2222_3333_4444;
        exp_w[2] = 64'h5555_6666_7777_8888;
        exp_w[3] = 64'hDEAD_9999_AAAA_BBBB;

        // ---- reset values ----
        tick(); tick();
        check("rst_burst_read", burst_read, 1'b0);
        check("rst_burst_write", burst_write, 1'b0);
        check("rst_pmem_resp", pmem_resp, 1'b0);
        check("rst_burst_address", burst_address, 32'h0);
        check("rst_burst_wdata", burst_wdata, 64'h0);
        check("rst_pmem_rdata", pmem_rdata, 256'h0);
        rst = 1'b0;
        tick();

        // ---- stray burst_resp in IDLE ----
        burst_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_pmem_resp", pmem_resp, 1'b0);
            check("stray_burst_busy", burst_read || burst_write, 1'b0);
        end
        burst_resp = 1'b0;

        // ---- directed read, back-to-back beats ----
        pmem_address = 32'h0000_1234;
        pmem_read = 1'b1;
        k = 0; lat = 0;
        while (!pmem_resp && lat < 20) begin
            if (burst_read) begin
                burst_resp = 1'b1;
                burst_rdata = pat(k);
                k++;
            end else begin
                burst_resp = 1'b0;
            end
            tick();
            lat++;
            if (lat == 1) check("rd_burst_address", burst_address, 32'h0000_1220);
        end
        burst_resp = 1'b0;
        pmem_read = 1'b0;
        check("rd_latency_edges", lat, 5);
        check("rd_line", pmem_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        tick();
        check("rd_resp_single", pmem_resp, 1'b0);

        // ---- reset mid-read after two beats ----
        pmem_address = $urandom;
        pmem_read = 1'b1;
        tick();
        burst_resp = 1'b1;
        burst_rdata = 64'hCAFE_F00D_0000_0001;
        tick();
        burst_rdata = 64'hCAFE_F00D_0000_0002;
        tick();
        rst = 1'b1; pmem_read = 1'b0; burst_resp = 1'b0;
        tick();
        check("rstmid_burst_read", burst_read, 1'b0);
        check("rstmid_pmem_resp", pmem_resp, 1'b0);
        check("rstmid_burst_address", burst_address, 32'h0);
        rst = 1'b0;
        tick();
        pmem_address = 32'h0000_4440;
        pmem_read = 1'b1;
        wait_resp();

        // ---- directed write with 2-cycle stalls between beats ----
        drain();
        wline = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};
        pmem_wdata = wline;
        pmem_address = 32'h0000_ABCD;
        pmem_write = 1'b1;
        burst_resp = 1'b0;
        tick();
        if (POSTED) begin
            check("wr_posted_resp", pmem_resp, 1'b1);
            pmem_write = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 3; s++) begin
                burst_resp = (s == 2);
                check("wr_burst_write", burst_write, 1'b1);
                check("wr_beat", burst_wdata, exp_w[b]);
                tick();
            end
        end
        burst_resp = 1'b0;
        check("wr_burst_write_off", burst_write, 1'b0);
        check("wr_final_resp", pmem_resp, !POSTED);
        pmem_write = 1'b0;
        tick();
        check("wr_resp_single", pmem_resp, 1'b0);

        // ---- read and write both high: write wins ----
        drain();
        pmem_address = $urandom;
        pmem_wdata = {8{$urandom}};
        pmem_read = 1'b1;
        pmem_write = 1'b1;
        burst_resp = 1'b0;
        tick();
        check("both_burst_write", burst_write, 1'b1);
        check("both_no_burst_read", burst_read, 1'b0);
        wait_resp();

`ifdef PMEM_POSTED_WRITE_EN
        // ---- posted write followed immediately by a read of the same line ----
        drain();
        pmem_address = 32'h0001_2340;
        pmem_wdata = {8{$urandom}};
        pmem_write = 1'b1;
        tick();
        check("pw_resp_t1", pmem_resp, 1'b1);
        pmem_write = 1'b0;
        pmem_read = 1'b1;
        pmem_address = 32'h0001_2350;
        k = 0; wb = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (burst_read) begin
                check("pw_read_after_write", wb, 4);
                burst_rdata = pat(k);
                k++;
            end else begin
                burst_rdata = {$urandom, $urandom};
            end
            burst_resp = 1'b1;
            if (burst_write) wb++;
            tick();
            done = pmem_resp;
        end
        check("pw_read_resp", pmem_resp, 1'b1);
        check("pw_read_line", pmem_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        pmem_read = 1'b0;
        burst_resp = 1'b0;
        tick();
`endif

        // ---- randomized traffic, checked by the model ----
        drain();
        for (int t = 0; t < 150; t++) begin
            int kind;
            kind = $urandom % 4;
            pmem_address = $urandom;
            pmem_wdata = {8{$urandom}};
            pmem_read  = (kind != 2);
            pmem_write = (kind >= 2);
            if ($urandom % 10 == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    rand_mem();
                    tick();
                end
                rst = 1'b1;
                pmem_read = 1'b0;
                pmem_write = 1'b0;
                rand_mem();
                tick();
                rst = 1'b0;
            end else begin
                wait_resp();
            end
            repeat ($urandom % 3) begin
                rand_mem();
                tick();
            end
        end
        drain();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
